// File: rtl/alu_issue.sv
// alu_issue: in-order issue and 4x4-bit register file stage feeding a 4-bit add/nand ALU
module alu_issue (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_sel,
    input  logic [3:0] alu_res,
    output logic       done,
    output logic       zero,
    input  logic [1:0] dbg_sel,
    output logic [3:0] dbg_data
);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t     r_state;
    logic [7:0] r_instr;
    logic [3:0] r_regs [4];
    logic [3:0] w_wdata;
    // LDI takes its immediate; ADD/NAND take the ALU result
    assign w_wdata     = r_instr[7] ? r_instr[3:0] : alu_res;
    assign instr_ready = rst_n && (r_state == IDLE);
    assign dbg_data    = r_regs[dbg_sel];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_instr <= '0;
            r_regs  <= '{default: '0};
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= 1'b0;
            done    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == IDLE) begin
                if (instr_valid) begin
                    r_instr <= instr;
                    r_state <= EXEC;
                    if (!instr[7]) begin
                        alu_a   <= r_regs[instr[3:2]];
                        alu_b   <= r_regs[instr[1:0]];
                        alu_sel <= instr[6];
                    end
                end
            end else begin
                r_state <= IDLE;
                done    <= 1'b1;
                if (r_instr[7:6] != 2'b11) begin
                    r_regs[r_instr[5:4]] <= w_wdata;
                    zero                 <= (w_wdata == 4'd0);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed checks of alu_issue against hand-computed register and flag values
module tb_alu_issue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [7:0] instr = '0;
    logic [3:0] alu_a, alu_b, alu_res;
    logic       alu_sel, done, zero;
    logic [1:0] dbg_sel = '0;
    logic [3:0] dbg_data;
    int         total = 0, bad = 0, n_done = 0;
    logic [3:0] ea, eb;
    logic       es;
    logic [7:0] q [3];

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
        .done(done), .zero(zero), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    assign alu_res = alu_sel ? ~(alu_a & alu_b) : alu_a + alu_b;
    always #5 clk = ~clk;
    always @(negedge clk) if (done) n_done++;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reg_chk(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        dbg_sel = idx;
        #1;
        chk(tag, {4'h0, dbg_data}, {4'h0, exp});
    endtask

    task automatic run(input logic [7:0] ins);
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        chk("rdy_idle", {7'h0, instr_ready}, 8'h1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("rdy_exec", {7'h0, instr_ready}, 8'h0);
        chk("done_exec", {7'h0, done}, 8'h0);
        ea = alu_a;
        eb = alu_b;
        es = alu_sel;
        @(negedge clk);
        chk("done_ret", {7'h0, done}, 8'h1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rdy_in_rst", {7'h0, instr_ready}, 8'h0);
        rst_n = 1'b1;
        #1;
        chk("rdy_rel", {7'h0, instr_ready}, 8'h1);
        chk("done_rst", {7'h0, done}, 8'h0);
        chk("zero_rst", {7'h0, zero}, 8'h0);
        for (int i = 0; i < 4; i++) reg_chk("r_rst", 2'(i), 4'h0);
        // LDI r1,3 ; LDI r2,4 ; ADD r3=r1+r2
        run(8'h93);
        run(8'hA4);
        run(8'h36);
        chk("add_a", {4'h0, ea}, 8'h3);
        chk("add_b", {4'h0, eb}, 8'h4);
        chk("add_sel", {7'h0, es}, 8'h0);
        reg_chk("r3_add", 2'd3, 4'h7);
        chk("zero_add", {7'h0, zero}, 8'h0);
        chk("n_done3", 8'(n_done), 8'd3);
        // NAND r0=r1 nand r2
        run(8'h46);
        chk("nand_sel", {7'h0, es}, 8'h1);
        reg_chk("r0_nand", 2'd0, 4'hF);
        // LDI leaves ALU inputs untouched
        run(8'h99);
        chk("ldi_hold_a", {4'h0, alu_a}, 8'h3);
        chk("ldi_hold_sel", {7'h0, alu_sel}, 8'h1);
        run(8'hA7);
        run(8'h26);
        reg_chk("r2_wrap", 2'd2, 4'h0);
        chk("zero_wrap", {7'h0, zero}, 8'h1);
        run(8'h15);
        reg_chk("r1_alias", 2'd1, 4'h2);
        chk("zero_alias", {7'h0, zero}, 8'h0);
        // streaming with valid held: LDI r3,0 ; NOP ; ADD r0=r3+r1
        q = '{8'hB0, 8'hC0, 8'h0D};
        n_done = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("s_rdy1", {7'h0, instr_ready}, 8'h1);
            instr = q[k];
            @(negedge clk);
            chk("s_rdy0", {7'h0, instr_ready}, 8'h0);
            chk("s_done0", {7'h0, done}, 8'h0);
            @(negedge clk);
            chk("s_done1", {7'h0, done}, 8'h1);
            if (k == 1) begin
                chk("nop_zero", {7'h0, zero}, 8'h1);
                reg_chk("nop_r3", 2'd3, 4'h0);
                reg_chk("nop_r1", 2'd1, 4'h2);
                reg_chk("nop_r0", 2'd0, 4'hF);
            end
        end
        instr_valid = 1'b0;
        reg_chk("s_r0", 2'd0, 4'h2);
        chk("s_zero", {7'h0, zero}, 8'h0);
        chk("s_ndone", 8'(n_done), 8'd3);
        // reset during EXEC drops the in-flight ADD
        run(8'hB5);
        @(negedge clk);
        instr = 8'h36;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rdy_rst_exec", {7'h0, instr_ready}, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rx_done", {7'h0, done}, 8'h0);
        chk("rx_rdy", {7'h0, instr_ready}, 8'h1);
        chk("rx_a", {4'h0, alu_a}, 8'h0);
        chk("rx_b", {4'h0, alu_b}, 8'h0);
        chk("rx_sel", {7'h0, alu_sel}, 8'h0);
        chk("rx_zero", {7'h0, zero}, 8'h0);
        reg_chk("rx_r3", 2'd3, 4'h0);
        reg_chk("rx_r0", 2'd0, 4'h0);
        chk("rx_ndone", 8'(n_done), 8'd4);
        run(8'hA6);
        reg_chk("post_r2", 2'd2, 4'h6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Issue and register-file stage directly upstream of the 4-bit `alu`. It accepts 8-bit instructions over a valid/ready handshake and holds four 4-bit general registers. For each instruction it drives the ALU operand and select inputs from registers, then writes the ALU result back to the destination register. Instructions execute strictly in order, one at a time, so there are no data hazards.

## Interface
Parameters:
- none; data width is fixed at 4 bits and register count at 4.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous active-low reset.
- `instr_valid` input 1: `instr` holds a valid instruction.
- `instr_ready` output 1: block can accept an instruction this cycle.
- `instr` input 8: instruction word.
- `alu_a` output 4: ALU operand A (registered).
- `alu_b` output 4: ALU operand B (registered).
- `alu_sel` output 1: 0 = add, 1 = nand (registered).
- `alu_res` input 4: combinational result from the ALU.
- `done` output 1: one-cycle pulse when an instruction retires.
- `zero` output 1: zero flag from the last register write.
- `dbg_sel` input 2: debug read register index.
- `dbg_data` output 4: combinational read of register `dbg_sel`.

## Operation
- Instruction fields:
  - `[7:6]` op: 00 ADD, 01 NAND, 10 LDI, 11 NOP.
  - `[5:4]` rd.
  - `[3:2]` rs.
  - `[1:0]` rt.
  - For LDI, the immediate is `[3:0]`.
- ADD: `rd <= alu_res`, with `alu_a = R[rs]`, `alu_b = R[rt]`, `alu_sel = 0`.
- NAND: same operand routing, with `alu_sel = 1`.
- LDI: `rd <= imm`.
  - The ALU result is ignored.
  - `alu_a`, `alu_b` and `alu_sel` keep their previous values.
- NOP: no register or flag write; `done` still pulses.
- All 4 registers are writable; there is no hardwired zero register.
- `rs`, `rt` and `rd` may alias, e.g. ADD r1 = r1 + r1 is legal.
- Arithmetic is modulo 16. Carry is discarded; the ALU exposes none.
- `zero` updates on every register write: 1 if the written value is 0, else 0. NOP leaves `zero` unchanged.
- FSM states: IDLE, EXEC.
  - IDLE: `instr_ready` = 1. On `instr_valid & instr_ready`, latch `instr`, load `alu_a`/`alu_b`/`alu_sel` (unless LDI/NOP), and go to EXEC.
  - EXEC: `instr_ready` = 0. At the end of the cycle, write `rd` (ADD/NAND from `alu_res`, LDI from imm), update `zero`, set `done` for the next cycle, and go to IDLE.
- `instr_valid` while `instr_ready` = 0 is ignored. The source must hold `instr` until accepted.

## Timing
- Reset (`rst_n` low at a rising edge) puts every output and register in a known state:
  - state = IDLE.
  - R0..R3 = 0.
  - `alu_a` = `alu_b` = 0, `alu_sel` = 0.
  - `done` = 0, `zero` = 0.
  - `instr_ready` = 0 while `rst_n` is low, and 1 on the first cycle after release.
- Accept at edge T0.
- Cycle T0→T1 (EXEC): ALU inputs are stable. `alu_res` must settle within this cycle.
- Edge T1: register write and flag update.
- Cycle T1→T2: `done` = 1, `instr_ready` = 1, and the new value is visible on `dbg_data`.
- Throughput: one instruction per 2 cycles. The earliest next accept is T2, and it sees the updated register file.
- Reset asserted during EXEC: the in-flight instruction is dropped with no write and no `done`; all reset values apply.
- `dbg_data` is combinational from the register array and reflects a write on the cycle after the write edge.

## Test plan
- Reset release → `instr_ready` = 1; `dbg_data` = 0 for `dbg_sel` 0..3; `done` = 0, `zero` = 0.
- LDI r1, 3 then LDI r2, 4 then ADD r3 = r1 + r2 → in EXEC, `alu_a` = 3, `alu_b` = 4, `alu_sel` = 0; afterwards R3 = 7 and `zero` = 0; `done` pulses exactly 3 times, each 2 cycles after its accept.
- With R1 = 3 and R2 = 4, NAND r0 = r1 nand r2 → `alu_sel` = 1; R0 = 4'hF.
- LDI r1, 9; LDI r2, 7; ADD r2 = r1 + r2 → R2 = 0 (wrap), `zero` = 1. Then ADD r1 = r1 + r1 → R1 = 2, `zero` = 0.
- Hold `instr_valid` high continuously with a queue of 3 instructions → `instr_ready` alternates 1/0; each instruction is accepted exactly once, never during EXEC. A NOP in the sequence → `done` pulses, registers and `zero` unchanged.
- Accept ADD r3 = r1 + r2, then pull `rst_n` low during EXEC for 1 cycle → R3 = 0, no `done`, all outputs at reset values; the next LDI executes normally.
